note_sequencer: RTL and testbench

Produces the 4-bit `note` code consumed by the LED bar and tone stages: live note from 12 debounced keys, or playback of a recorded melody of up to `STEPS` notes at a fixed tempo. Codes 0..11 are semitones C..B; 4'hF is rest/silence. Sits between the raw board buttons and every note consumer.

---
 rtl/note_sequencer_pkg.sv | 29 ++
 rtl/note_sequencer_input_debouncer.sv | 49 ++++
 rtl/note_sequencer.sv | 174 +++++++++++++++++
 tb/tb_note_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// ==========================================================================
// note_sequencer_pkg : note codes, sequencer states, key priority helper
// Rev 1.0
// ==========================================================================
package note_sequencer_pkg;

  localparam int NOTE_W   = 4;
  localparam int NUM_KEYS = 12;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_t;

  // Lowest-index held key wins; nothing held means rest.
  function automatic logic [NOTE_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] keys);
    logic [NOTE_W-1:0] code;
    code = NOTE_REST;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) code = NOTE_W'(i);
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_input_debouncer.sv
`default_nettype none
// ==========================================================================
// input_debouncer : 2-FF synchronizers plus shared-prescaler two-sample debounce
// Rev 1.0
// ==========================================================================
module input_debouncer #(
  parameter int WIDTH          = 14,
  parameter int DEBOUNCE_TICKS = 100000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean
);

  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] last_sample;
  logic [WIDTH-1:0] agree;
  logic [CNT_W-1:0] presc;
  logic             tick;

  assign tick  = (presc == CNT_LAST);
  assign agree = ~(sync2 ^ last_sample);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1       <= '0;
      sync2       <= '0;
      presc       <= '0;
      last_sample <= '0;
      clean       <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        last_sample <= sync2;
        // A bit only moves when two consecutive samples agree.
        clean       <= (clean & ~agree) | (sync2 & agree);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ==========================================================================
// note_sequencer : live note from 12 keys, or record/playback of a short melody
// Rev 1.0
// ==========================================================================
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int STEPS          = 16,
  parameter int STEP_TICKS     = 2500000,
  parameter int DEBOUNCE_TICKS = 100000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] key,
  input  logic        rec_btn,
  input  logic        play_btn,
  output logic [3:0]  note,
  output logic        recording,
  output logic        playing,
  output logic [3:0]  step_idx
);

  localparam int PTR_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LEN_W  = PTR_W + 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(STEPS);

  logic [13:0]        db;
  logic               rec_q;
  logic               play_q;
  logic               rec_p;
  logic               play_p;
  logic [NOTE_W-1:0]  live;
  logic [NOTE_W-1:0]  live_prev;

  seq_state_t         state;
  seq_state_t         state_n;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   rd_ptr_n;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_n;
  logic [STEP_W-1:0]  step_cnt;
  logic [STEP_W-1:0]  step_cnt_n;
  logic               mem_we;
  logic [NOTE_W-1:0]  mem [STEPS];

  logic [NOTE_W-1:0]  note_n;
  logic               recording_n;
  logic               playing_n;
  logic [3:0]         step_idx_n;

  input_debouncer #(
    .WIDTH          (14),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debouncer (
    .clk   (clk),
    .rstn  (rstn),
    .raw   ({play_btn, rec_btn, key}),
    .clean (db)
  );

  assign rec_p  = db[12] & ~rec_q;
  assign play_p = db[13] & ~play_q;
  assign live   = lowest_key(db[11:0]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      len       <= '0;
      step_cnt  <= '0;
      rec_q     <= 1'b0;
      play_q    <= 1'b0;
      live_prev <= NOTE_REST;
      note      <= NOTE_REST;
      recording <= 1'b0;
      playing   <= 1'b0;
      step_idx  <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      len       <= len_n;
      step_cnt  <= step_cnt_n;
      rec_q     <= db[12];
      play_q    <= db[13];
      live_prev <= live;
      note      <= note_n;
      recording <= recording_n;
      playing   <= playing_n;
      step_idx  <= step_idx_n;
    end
  end

  // Melody storage is deliberately not reset; len=0 hides stale entries.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= live;
  end

  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    len_n      = len;
    step_cnt_n = step_cnt;
    mem_we     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (rec_p) begin
          state_n  = ST_REC;
          wr_ptr_n = '0;
          len_n    = '0;
        end else if (play_p && (len != '0)) begin
          state_n    = ST_PLAY;
          rd_ptr_n   = '0;
          step_cnt_n = '0;
        end
      end
      ST_REC: begin
        if (rec_p) begin
          state_n = ST_IDLE;
        end else if ((live_prev == NOTE_REST) && (live != NOTE_REST)) begin
          mem_we   = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          len_n    = len + 1'b1;
          if (len_n == LEN_FULL) state_n = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (rec_p) begin
          state_n  = ST_REC;
          wr_ptr_n = '0;
          len_n    = '0;
        end else if (play_p) begin
          state_n = ST_IDLE;
        end else if (step_cnt == STEP_LAST) begin
          step_cnt_n = '0;
          rd_ptr_n   = (({1'b0, rd_ptr} + 1'b1) == len) ? '0 : rd_ptr + 1'b1;
        end else begin
          step_cnt_n = step_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs follow the current registers, so they land one cycle later.
  always_comb begin
    note_n      = live;
    recording_n = 1'b0;
    playing_n   = 1'b0;
    step_idx_n  = '0;
    case (state)
      ST_REC: begin
        recording_n = 1'b1;
        step_idx_n  = 4'(wr_ptr);
      end
      ST_PLAY: begin
        playing_n  = 1'b1;
        step_idx_n = 4'(rd_ptr);
        if (live == NOTE_REST) note_n = mem[rd_ptr];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_note_sequencer : randomized stimulus against a cycle-count melody model
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam int STEPS      = 4;
  localparam int STEP_TICKS = 10;
  localparam int DEB_TICKS  = 4;
  localparam int SETTLE     = 16;
  localparam int KEY_LAT    = 2 + 2 * DEB_TICKS + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] key = '0;
  logic        rec_btn = 1'b0;
  logic        play_btn = 1'b0;
  logic [3:0]  note;
  logic        recording;
  logic        playing;
  logic [3:0]  step_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int mel[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_sequencer #(
    .STEPS          (STEPS),
    .STEP_TICKS     (STEP_TICKS),
    .DEBOUNCE_TICKS (DEB_TICKS)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key       (key),
    .rec_btn   (rec_btn),
    .play_btn  (play_btn),
    .note      (note),
    .recording (recording),
    .playing   (playing),
    .step_idx  (step_idx)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_live(input logic [11:0] k);
    for (int i = 0; i < 12; i++) if (k[i]) return i;
    return 15;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_note(input string tag, input int exp, input int limit);
    int n;
    n = 0;
    while (note !== 4'(exp) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, note, exp);
  endtask

  // which: 0 = rec, 1 = play, 2 = both together
  task automatic press_btn(input int which);
    rec_btn  = (which == 0 || which == 2);
    play_btn = (which == 1 || which == 2);
    cycles(SETTLE);
    rec_btn  = 1'b0;
    play_btn = 1'b0;
    cycles(SETTLE);
  endtask

  task automatic tap(input int k);
    key = '0;
    key[k] = 1'b1;
    cycles(SETTLE);
    key = '0;
    cycles(SETTLE);
  endtask

  task automatic start_play();
    int n;
    n = 0;
    play_btn = 1'b1;
    while (playing !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_value("play_start", playing, 1);
    t0 = cyc;
    play_btn = 1'b0;
  endtask

  // Expected step is purely elapsed cycles since playback began.
  task automatic play_check(input string tag, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      int idx;
      idx = ((cyc - t0) / STEP_TICKS) % mel.size();
      check_value({tag, " note"}, note, mel[idx]);
      check_value({tag, " step_idx"}, step_idx, idx);
      @(negedge clk);
    end
  endtask

  task automatic expect_no_play(input string tag);
    logic seen;
    seen = 1'b0;
    play_btn = 1'b1;
    for (int n = 0; n < 2 * SETTLE; n++) begin
      @(negedge clk);
      if (playing) seen = 1'b1;
    end
    play_btn = 1'b0;
    cycles(SETTLE);
    check_value(tag, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] mask;
    logic        saw5;
    int          k;

    rstn = 1'b0;
    cycles(3);
    check_value("rst note", note, 15);
    check_value("rst recording", recording, 0);
    check_value("rst playing", playing, 0);
    check_value("rst step_idx", step_idx, 0);
    rstn = 1'b1;
    cycles(2);

    key = 12'h008;
    wait_note("key3", 3, KEY_LAT);
    key = '0;
    wait_note("key3 release", 15, KEY_LAT);

    saw5 = 1'b0;
    key[5] = 1'b1;
    cycles(2);
    key = '0;
    for (int n = 0; n < 2 * SETTLE; n++) begin
      @(negedge clk);
      if (note == 4'd5) saw5 = 1'b1;
    end
    check_value("glitch key5", saw5, 0);

    key = 12'h084;
    wait_note("keys 7+2", 2, KEY_LAT);
    key[2] = 1'b0;
    wait_note("key7 after 2 release", 7, KEY_LAT);
    key = '0;
    wait_note("release all", 15, KEY_LAT);

    for (int i = 0; i < 8; i++) begin
      mask = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) mask = '0;
      key = mask;
      wait_note("random live", model_live(mask), SETTLE);
    end
    key = '0;
    wait_note("random release", 15, SETTLE);

    expect_no_play("play with len 0");

    mel.delete();
    mel.push_back(4); mel.push_back(9); mel.push_back(0);
    press_btn(0);
    check_value("rec enter", recording, 1);
    check_value("rec wr_ptr 0", step_idx, 0);
    for (int i = 0; i < 3; i++) begin
      tap(mel[i]);
      check_value("rec wr_ptr", step_idx, i + 1);
    end
    press_btn(0);
    check_value("rec exit", recording, 0);

    start_play();
    play_check("mel1", 3 * 3 * STEP_TICKS);
    key[11] = 1'b1;
    wait_note("preview 11", 11, SETTLE);
    cycles(20);
    check_value("preview hold", note, 11);
    key = '0;
    cycles(SETTLE);
    play_check("resume", 25);
    press_btn(1);
    check_value("stop playing", playing, 0);
    check_value("stop step_idx", step_idx, 0);

    mel.delete();
    press_btn(0);
    for (int i = 0; i < STEPS; i++) begin
      k = int'($urandom_range(0, 11));
      mel.push_back(k);
      tap(k);
      if (i == STEPS - 2) check_value("rec before full", recording, 1);
    end
    check_value("auto return", recording, 0);
    check_value("auto return idx", step_idx, 0);
    start_play();
    play_check("mel2", 3 * STEPS * STEP_TICKS);

    press_btn(2);
    check_value("both -> rec", recording, 1);
    check_value("both -> not playing", playing, 0);
    check_value("both -> wr_ptr 0", step_idx, 0);
    tap(int'($urandom_range(0, 11)));
    check_value("rec after both", step_idx, 1);

    rstn = 1'b0;
    @(negedge clk);
    check_value("midrec rst note", note, 15);
    check_value("midrec rst recording", recording, 0);
    check_value("midrec rst playing", playing, 0);
    check_value("midrec rst step_idx", step_idx, 0);
    rstn = 1'b1;
    cycles(2);
    expect_no_play("play after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
